// File: rtl/imem_pkg.sv
// Shared widths, the fault instruction word and the response record used by the
// instruction-memory responder and its response FIFO.
package imem_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 64;

    // BRK #0: a faulting fetch hands the core a trapping instruction.
    localparam logic [INST_W-1:0] BRK0_INST = 32'hD420_0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic              fault;
    } imem_resp_t;

endpackage

// File: rtl/imem_resp_fifo.sv
// In-order response buffer: synchronous FIFO of imem_resp_t with a live head,
// occupancy count, and a push accepted while full when a pop frees the slot.
module imem_resp_fifo
    import imem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  imem_resp_t       push_data_i,
    input  logic             pop_i,
    output imem_resp_t       head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    imem_resp_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every signal driven here gets a value on every path before any
    // condition is tested, so no latch can be inferred.
    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CNT_W'(DEPTH));
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        head_o   = mem_q[rd_ptr_q];
        count_o  = count_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; only the pointers and count
    // decide what is valid, which keeps this mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: preloadable word array, pc decode with fault
// generation, fixed-latency pipeline and in-order response FIFO with credit
// flow control. Define IMEM_STATS_EN to add saturating statistics counters.
module imem_responder
    import imem_pkg::*;
#(
    parameter  int                DEPTH_WORDS = 1024,
    parameter  logic [ADDR_W-1:0] BASE_ADDR   = 64'h0,
    parameter  int                LATENCY     = 2,
    parameter  int                FIFO_DEPTH  = 4,
    localparam int                IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [INST_W-1:0] resp_inst,
    output logic              resp_fault,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [INST_W-1:0] ld_data
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0]       stat_reqs,
    output logic [31:0]       stat_faults,
    output logic [31:0]       stat_stall
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [INST_W-1:0] mem_q [DEPTH_WORDS];
    logic [ADDR_W-1:0] off;
    logic [1:0]        unused_off_lsb;
    logic              accept, push, pop;
    imem_resp_t        lookup, push_data, head;
    logic [CNT_W-1:0]  inflight, fifo_count;
    logic              fifo_empty, unused_fifo_full;

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

    // Misalignment is judged on the pc itself, so the low offset bits carry nothing further.
    always_comb begin
        off            = req_addr - BASE_ADDR;
        unused_off_lsb = off[1:0];
        lookup.fault   = (req_addr[1:0] != 2'b00) || (off[ADDR_W-1:IDX_W+2] != '0);
        lookup.inst    = lookup.fault ? BRK0_INST : mem_q[off[IDX_W+1:2]];
    end

    // Credits cover both in-flight stages and buffered responses, so a push never meets a full FIFO.
    assign req_ready = !reset && ((inflight + fifo_count) < CNT_W'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    // The FIFO write is the final latency stage, hence LATENCY-1 register stages here.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push      = accept;
            assign push_data = lookup;
            assign inflight  = '0;
        end else begin : g_pipe
            localparam int STAGES = LATENCY - 1;
            logic [STAGES-1:0] vld_q;
            imem_resp_t        data_q [STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= accept;
                    for (int s = 1; s < STAGES; s++) begin
                        vld_q[s] <= vld_q[s-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                data_q[0] <= lookup;
                for (int s = 1; s < STAGES; s++) begin
                    data_q[s] <= data_q[s-1];
                end
            end

            always_comb begin
                inflight = '0;
                for (int s = 0; s < STAGES; s++) begin
                    inflight = inflight + CNT_W'(vld_q[s]);
                end
            end

            assign push      = vld_q[STAGES-1];
            assign push_data = data_q[STAGES-1];
        end
    endgenerate

    imem_resp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .full_o      (unused_fifo_full),
        .empty_o     (fifo_empty)
    );

    assign resp_valid = !fifo_empty;
    assign pop        = resp_valid && resp_ready;
    assign resp_inst  = resp_valid ? head.inst : '0;
    assign resp_fault = resp_valid && head.fault;

`ifdef IMEM_STATS_EN
    logic [31:0] stat_reqs_q, stat_faults_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_reqs_q   <= '0;
            stat_faults_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (accept && (stat_reqs_q != '1)) begin
                stat_reqs_q <= stat_reqs_q + 32'd1;
            end
            if (push && push_data.fault && (stat_faults_q != '1)) begin
                stat_faults_q <= stat_faults_q + 32'd1;
            end
            if (req_valid && !req_ready && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_reqs   = stat_reqs_q;
    assign stat_faults = stat_faults_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: the driver queues the expected response at
// each accepted request; a negedge monitor pops and compares every delivered response.
module tb_imem_responder;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_inst;
    logic        resp_fault;
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    imem_resp_t  exp_q [$];
    int          pop_cyc [$];
    logic        held     = 1'b0;
    logic [31:0] held_inst;

    logic [31:0] prog [4] = '{32'h9100_0421, 32'h9100_0842, 32'hD503_201F, 32'h1400_0000};

    imem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (64'h0),
        .LATENCY     (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_fault (resp_fault),
        .ld_en      (ld_en),
        .ld_idx     (ld_idx),
        .ld_data    (ld_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each delivered response and the stability of stalled ones.
    always @(negedge clk) begin
        if (resp_valid && held) begin
            check("resp_stable", resp_inst, held_inst);
        end
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp_count", 64'd1, 64'd0);
            end else begin
                imem_resp_t e;
                e = exp_q.pop_front();
                check("resp_inst", resp_inst, e.inst);
                check("resp_fault", resp_fault, e.fault);
            end
            pop_cyc.push_back(cyc);
        end
        held      = resp_valid && !resp_ready;
        held_inst = resp_inst;
    end

    task automatic send(input logic [63:0] addr, input logic [31:0] inst, input logic fault,
                        output int waited);
        waited    = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check("req_accept", req_ready, 1'b1);
        if (req_ready) exp_q.push_back('{inst: inst, fault: fault});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (exp_q.size() != 0 && n < 100);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        int accepted;

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
        ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        // Preload while reset is held.
        for (int i = 0; i < 5; i++) begin
            ld_en   = 1'b1;
            ld_idx  = (i < 4) ? 10'(i) : 10'd1023;
            ld_data = (i < 4) ? prog[i] : 32'h1234_5678;
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_inst", resp_inst, 32'h0);
        check("rst_resp_fault", resp_fault, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single fetch: response eligible exactly two cycles after acceptance.
        send(64'h0, prog[0], 1'b0, w);
        @(negedge clk);
        check("lat_cycle1_valid", resp_valid, 1'b0);
        @(negedge clk);
        check("lat_cycle2_valid", resp_valid, 1'b1);
        drain();

        // Back-to-back stream with responses on consecutive cycles.
        pop_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            send(64'(i * 4), prog[i], 1'b0, w);
            check("stream_no_wait", w, 0);
        end
        drain();
        check("stream_resp_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) check("stream_consecutive", pop_cyc[i] - pop_cyc[i-1], 1);
        end

        // Faults: misaligned, past the end, negative wrap; plus the last valid word.
        send(64'h6, BRK0_INST, 1'b1, w);
        send(64'h1000, BRK0_INST, 1'b1, w);
        send(64'hFFFF_FFFF_FFFF_FFFC, BRK0_INST, 1'b1, w);
        send(64'hFFC, 32'h1234_5678, 1'b0, w);
        drain();

        // Backpressure: credits cap acceptance at four.
        resp_ready = 1'b0;
        accepted   = 0;
        req_valid  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_addr = 64'((accepted % 4) * 4);
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back('{inst: prog[accepted % 4], fault: 1'b0});
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("bp_accepted", accepted, 4);
        @(negedge clk);
        check("bp_full_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_at_first_pop", req_ready, 1'b0);
        @(negedge clk);
        check("bp_ready_after_pop", req_ready, 1'b1);
        drain();

        // Reset with three requests outstanding flushes everything.
        resp_ready = 1'b0;
        send(64'h0, prog[0], 1'b0, w);
        send(64'h4, prog[1], 1'b0, w);
        send(64'h8, prog[2], 1'b0, w);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_req_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_resp_valid", resp_valid, 1'b0);
        check("flush_resp_inst", resp_inst, 32'h0);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(64'h4, prog[1], 1'b0, w);
        drain();

        // Load in the acceptance cycle: the read sees the old word, the next read the new one.
        ld_en   = 1'b1;
        ld_idx  = 10'd1;
        ld_data = 32'hAAAA_AAAA;
        send(64'h4, prog[1], 1'b0, w);
        ld_en = 1'b0;
        check("ld_same_cycle_no_wait", w, 0);
        send(64'h4, 32'hAAAA_AAAA, 1'b0, w);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the far side of the core's fetch interface.
- The cpu core issues fetch requests carrying a 64-bit pc; this block returns 32-bit A64 instruction words after a fixed pipeline latency, with valid/ready flow control both ways.
- The memory array is written through a load port so benches preload programs before releasing reset to the core.
- Sits between cpu and the bench/top level.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
BASE_ADDR, 64'h0, byte address mapped to word 0
LATENCY, 2, cycles from request acceptance to response eligibility (1..4)
FIFO_DEPTH, 4, response buffer entries; also caps outstanding requests (>= LATENCY)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  fetch request valid
req_ready  out  1  responder can accept a request
req_addr  in  64  fetch byte address (pc)
resp_valid  out  1  response available
resp_ready  in  1  core accepts response
resp_inst  out  32  instruction word
resp_fault  out  1  fetch fault for this response
ld_en  in  1  array write strobe (preload)
ld_idx  in  $clog2(DEPTH_WORDS)  word index to write
ld_data  in  32  word to write

Behaviour:
- Reset (sync, active-high): req_ready=0 during reset, 1 the cycle after; resp_valid=0, resp_inst=0, resp_fault=0; pipeline and FIFO flushed, credit count=0. Array contents NOT cleared.
- Request accepted on req_valid & req_ready. req_ready = (inflight + fifo_count) < FIFO_DEPTH.
- Accepted request enters a LATENCY-stage pipeline (valid bit, word, fault). It pushes into the response FIFO at the end of stage LATENCY. resp_valid rises exactly LATENCY cycles after acceptance if the FIFO was empty.
- Responses are returned strictly in request order. Pop on resp_valid & resp_ready. resp_* stay stable while resp_valid & !resp_ready.
- Address decode: off = req_addr - BASE_ADDR (64-bit wrap).
  - Fault if req_addr[1:0] != 0 (misaligned), or off >= DEPTH_WORDS*4 (out of range, including negative wrap).
  - Fault response: resp_fault=1, resp_inst=32'hD4200000 (BRK #0).
  - Else resp_inst = mem[off>>2], resp_fault=0.
- Array read occurs at acceptance cycle.
- ld_en in the same cycle as an accepted read of the same index: the read returns the OLD data. ld_en is honoured during reset.
- Credit: pipeline push and FIFO pop in the same cycle leave the count unchanged. A FIFO push and pop while the FIFO is full is legal (full throughput). Back-to-back one request per cycle is sustained when resp_ready=1.
- No state machine beyond the pipeline/FIFO; the block never drops or reorders responses.

Optional Feature:
IMEM_STATS_EN
- Defined: adds outputs stat_reqs[31:0] (accepted requests), stat_faults[31:0] (fault responses pushed), stat_stall[31:0] (cycles with req_valid & !req_ready). All are saturating and cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package imem_pkg: INST_W=32, ADDR_W=64, BRK0_INST=32'hD4200000, typedef imem_resp_t {inst, fault}.
- One sub-module, imem_resp_fifo: synchronous FIFO of imem_resp_t with count, full and empty outputs, and same-cycle push/pop when full.
- Array, decode and pipeline live in imem_responder.

Test Plan:
- Preload mem[0..3]=0x91000421,0x91000842,0xD503201F,0x14000000 with BASE_ADDR=0, LATENCY=2; request addr 0x0 -> resp_valid exactly 2 cycles later, resp_inst=0x91000421, fault=0.
- Stream addrs 0x0,0x4,0x8,0xC on consecutive cycles with resp_ready=1 -> four in-order responses on 4 consecutive cycles, req_ready stays 1.
- Request addr 0x6 -> resp_fault=1, resp_inst=0xD4200000. Request addr 0x1000 (DEPTH_WORDS=1024) -> fault.
- resp_ready=0, issue requests continuously -> exactly FIFO_DEPTH=4 accepted, then req_ready=0. Raise resp_ready -> 4 responses in order, and req_ready returns 1 the cycle after the first pop.
- Assert reset for 1 cycle with 3 requests outstanding -> resp_valid=0 next cycle, no stale responses ever appear; a subsequent request to 0x4 returns 0x91000842.
- ld_en idx 1 data 0xAAAAAAAA in the same cycle as a request to 0x4 -> returns 0x91000842; the next request to 0x4 returns 0xAAAAAAAA.
